// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns load-use, branch and data-memory
// wait hazards into PC/IF-ID enables, flush and bubble controls, with perf counters.
module pipe_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs2,
    input  logic             ID_EX_mem_read,
    input  logic [4:0]       ID_EX_rd,
    input  logic             pc_src,
    input  logic             EX_MEM_mem_req,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_flush,
    output logic             ID_EX_bubble,
    output logic             pipe_hold,
    output logic             MEM_WB_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic            err_nxt;
    logic            freeze_raw, req_raw, freeze, load_use;

    assign load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2)));

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        to_nxt     = to_cnt;
        err_nxt    = mem_err;
        freeze_raw = 1'b0;
        req_raw    = 1'b0;
        unique case (state)
            RUN: begin
                req_raw = EX_MEM_mem_req;
                if (EX_MEM_mem_req && !dmem_ready) begin
                    freeze_raw = 1'b1;
                    state_nxt  = MEM_WAIT;
                    to_nxt     = TO_ONE;
                end
            end
            MEM_WAIT: begin
                req_raw = 1'b1;
                // The completing cycle lets the pipeline advance with the returned data.
                if (dmem_ready) begin
                    state_nxt = RUN;
                    to_nxt    = '0;
                end else begin
                    freeze_raw = 1'b1;
                    if (to_cnt == TO_MAX) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        to_nxt = to_cnt + TO_ONE;
                    end
                end
            end
            ERR: begin
                freeze_raw = 1'b1;
                if (err_clr) begin
                    state_nxt = RUN;
                    err_nxt   = 1'b0;
                    to_nxt    = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // While reset is held any in-flight access is abandoned, so request and freeze drop at once.
    assign dmem_req = req_raw && rst_n;
    assign freeze   = freeze_raw && rst_n;

    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_flush      = 1'b0;
        ID_EX_bubble  = 1'b0;
        pipe_hold     = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (freeze) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            pipe_hold     = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else if (load_use) begin
            // Branch operands are stale here; the decoder re-resolves pc_src next cycle.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (pc_src) begin
            IF_flush = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            to_cnt    <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            to_cnt  <= to_nxt;
            mem_err <= err_nxt;
            if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
            if (IF_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule
